tmr_clock_select: RTL and testbench
===================================

Name: tmr_clock_select

Overview:
- Upstream count-source stage for one 8-bit timer channel.
- Turns the internal system clock, the partner channel's overflow, or the external TMCI pin into a one-cycle count-enable pulse for the channel counter.
- Also turns the external TMRI pin into a one-cycle counter-clear pulse.
- One instance per channel; the prescaler is local to each instance.

Parameters:
PRESCALE_WIDTH, 13, width of the free-running prescaler (supports division up to 8192)

Ports:
clk  input  1  system clock (Pφ)
reset_n  input  1  asynchronous, active-high reset (the name is historical; asserted = 1)
cks  input  3  clock-select field from the channel's TCR
icks0  input  1  internal-clock divider select bit from the channel's TCCR
tmci  input  1  external count clock pin, asynchronous to clk
tmri  input  1  external counter-reset pin, asynchronous to clk
tmri_en  input  1  enables the external reset function
tmris  input  1  0 = clear on rising edge of TMRI; 1 = clear while TMRI is high
ovf_in  input  1  one-cycle overflow pulse from the partner channel (cascade source)
count_en  output  1  one-cycle pulse: counter increments this cycle
ext_clr  output  1  counter-clear request from TMRI
presc_out  output  PRESCALE_WIDTH  current prescaler value (debug/visibility)

Behaviour:
Reset (asynchronous, active-high):
- Prescaler, all synchronizer/edge registers, count_en and ext_clr go to 0 immediately.
- After release, a TMCI or TMRI already high produces one rising-edge event, because the history registers start at 0.

Prescaler:
- PRESCALE_WIDTH-bit counter, increments every clk, wraps from all-ones to 0, never stops.
- Divide-by-N tick = (presc[log2(N)-1:0] == N-1); it fires once every N cycles, the first time at presc = N-1.

Synchronizers:
- TMCI and TMRI each pass through two flops (s1, s2), then one history flop (s3).
- rise = s2 & ~s3; fall = ~s2 & s3.

Source select (cks, icks0):
- 000: no source; count_en stays 0.
- 001: Pφ/8 if icks0 = 0, Pφ/2 if icks0 = 1.
- 010: Pφ/64 if icks0 = 0, Pφ/32 if icks0 = 1.
- 011: Pφ/8192 if icks0 = 0, Pφ/1024 if icks0 = 1.
- 100: cascade; source = ovf_in.
- 101: TMCI rising edge.
- 110: TMCI falling edge.
- 111: TMCI both edges.

count_en:
- Registered: equals the selected source term from the previous cycle.
- Always a single-cycle pulse; never high on two consecutive cycles except for Pφ/2, where it is high every other cycle.

Latencies:
- Internal tick: count_en is high in the cycle after presc = N-1.
- Cascade: 1 cycle after ovf_in.
- External: TMCI first sampled high at edge E0 → count_en high for the one cycle following edge E2.

ext_clr (registered):
- tmri_en = 0 → 0.
- tmris = 0 → one-cycle pulse one cycle after the TMRI rise term.
- tmris = 1 → follows s2 of TMRI, delayed one cycle; level, high for as long as the synchronized pin is high.

Selection changes:
- cks/icks0 changes take effect on the next clk; no glitch suppression.
- If the new divider's tick condition is already true, one pulse may occur immediately. This is accepted.
- The prescaler is never cleared by a selection change.

Simultaneous events:
- ext_clr and count_en are independent and may both be high in the same cycle.
- The downstream counter gives clear priority.

Pulse widths:
- TMCI high or low phases shorter than 2 clk may be missed.
- Software must guarantee a width of at least 2 cycles (1.5-cycle minimum per datasheet class).

Optional Feature:
Macro: TMR_INPUT_FILTER_EN
- Defined: a 3-sample agreement filter is inserted after s2 for both TMCI and TMRI. The filtered level changes only when three consecutive s2 samples agree. Edge detection and tmris level mode use the filtered level. External latency grows by 2 cycles (count_en follows edge E4). Pulses shorter than 3 cycles are rejected. The filter registers reset to 0.
- Not defined: no filter; edge detection operates directly on s2.

Test Plan:
- Reset, cks=001, icks0=0, run 64 cycles → exactly 8 count_en pulses, each one cycle after presc[2:0]=7; first pulse at the cycle after presc=7.
- cks=011, icks0=1 → count_en period 1024 cycles; cks=011, icks0=0 → period 8192; cks=000 → count_en stays 0 for 20000 cycles.
- cks=101; drive TMCI high 4 cycles / low 4 cycles for 10 periods → 10 count_en pulses, each 3 edges after the rise. cks=111 gives 20 pulses; cks=110 gives 10 pulses aligned to falls.
- cks=100; pulse ovf_in at cycles 10 and 300 → count_en at cycles 11 and 301 only.
- tmri_en=1, tmris=0, TMRI high for 6 cycles → single one-cycle ext_clr. tmris=1 → ext_clr high for 6 consecutive cycles. tmri_en=0 → ext_clr never asserts.
- Assert reset_n mid-stream (cks=001, TMCI toggling) → count_en, ext_clr and presc_out are 0 in the same cycle. With TMR_INPUT_FILTER_EN, a 2-cycle TMCI pulse → no count_en; a 3-cycle pulse → one count_en.

Source files
------------

// File: rtl/tmr_clock_select.sv
// Timer count-source stage: prescaler, TMCI/TMRI synchronizers, source mux. Optional filter: TMR_INPUT_FILTER_EN.
// Latency: internal tick and cascade 1 cycle; TMCI/TMRI 3 cycles from first sample (5 with the filter).
// Backpressure: none; count_en and ext_clr are free-running single-cycle or level outputs.

module tmr_pin_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic lvl,
    output logic lvl_q
);
    logic s1;
    logic s2;
    logic s3;
    logic lvl_now;

`ifdef TMR_INPUT_FILTER_EN
    logic h1;
    logic h2;

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            h1 <= 1'b0;
            h2 <= 1'b0;
        end else begin
            h1 <= s2;
            h2 <= h1;
        end
    end

    // Level only moves once three consecutive synchronized samples agree.
    always_comb begin
        lvl_now = s3;
        if (s2 && h1 && h2) begin
            lvl_now = 1'b1;
        end else if (!(s2 || h1 || h2)) begin
            lvl_now = 1'b0;
        end
    end
`else
    assign lvl_now = s2;
`endif

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pin;
            s2 <= s1;
            s3 <= lvl_now;
        end
    end

    assign lvl   = lvl_now;
    assign lvl_q = s3;
endmodule

module tmr_clock_select #(
    parameter int PRESCALE_WIDTH = 13
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [2:0]                cks,
    input  logic                      icks0,
    input  logic                      tmci,
    input  logic                      tmri,
    input  logic                      tmri_en,
    input  logic                      tmris,
    input  logic                      ovf_in,
    output logic                      count_en,
    output logic                      ext_clr,
    output logic [PRESCALE_WIDTH-1:0] presc_out
);
    localparam logic [PRESCALE_WIDTH-1:0] PRESC_ONE = {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};

    logic [PRESCALE_WIDTH-1:0] presc;
    logic tmci_lvl;
    logic tmci_q;
    logic tmri_lvl;
    logic tmri_q;
    logic tick_2;
    logic tick_8;
    logic tick_32;
    logic tick_64;
    logic tick_1024;
    logic tick_8192;
    logic src_term;
    logic clr_term;

    // Divide-by-2^log2n tick: low log2n prescaler bits all ones.
    function automatic logic div_tick(input logic [PRESCALE_WIDTH-1:0] p, input int log2n);
        logic [PRESCALE_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < PRESCALE_WIDTH; i++) begin
            if (i < log2n) begin
                m[i] = 1'b1;
            end
        end
        return (p & m) == m;
    endfunction

    tmr_pin_sync u_tmci_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .pin     (tmci),
        .lvl     (tmci_lvl),
        .lvl_q   (tmci_q)
    );

    tmr_pin_sync u_tmri_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .pin     (tmri),
        .lvl     (tmri_lvl),
        .lvl_q   (tmri_q)
    );

    assign tick_2    = div_tick(presc, 1);
    assign tick_8    = div_tick(presc, 3);
    assign tick_32   = div_tick(presc, 5);
    assign tick_64   = div_tick(presc, 6);
    assign tick_1024 = div_tick(presc, 10);
    assign tick_8192 = div_tick(presc, 13);

    always_comb begin
        src_term = 1'b0;
        case (cks)
            3'b001:  src_term = icks0 ? tick_2    : tick_8;
            3'b010:  src_term = icks0 ? tick_32   : tick_64;
            3'b011:  src_term = icks0 ? tick_1024 : tick_8192;
            3'b100:  src_term = ovf_in;
            3'b101:  src_term = tmci_lvl & ~tmci_q;
            3'b110:  src_term = ~tmci_lvl & tmci_q;
            3'b111:  src_term = tmci_lvl ^ tmci_q;
            default: src_term = 1'b0;
        endcase
    end

    always_comb begin
        clr_term = 1'b0;
        if (tmri_en) begin
            clr_term = tmris ? tmri_lvl : (tmri_lvl & ~tmri_q);
        end
    end

    // Selection changes are not cleaned up: prescaler keeps running across them.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            presc    <= '0;
            count_en <= 1'b0;
            ext_clr  <= 1'b0;
        end else begin
            presc    <= presc + PRESC_ONE;
            count_en <= src_term;
            ext_clr  <= clr_term;
        end
    end

    assign presc_out = presc;
endmodule

// File: tb/tb_tmr_clock_select.sv
// Bench for tmr_clock_select: table-driven source vectors, corner sequences, randomized run against a sample-history model.
module tb_tmr_clock_select;
    localparam int PW = 13;
`ifdef TMR_INPUT_FILTER_EN
    localparam int FL = 2;
`else
    localparam int FL = 0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [2:0]    cks = 3'b000;
    logic          icks0 = 1'b0;
    logic          tmci = 1'b0;
    logic          tmri = 1'b0;
    logic          tmri_en = 1'b0;
    logic          tmris = 1'b0;
    logic          ovf_in = 1'b0;
    logic          count_en;
    logic          ext_clr;
    logic [PW-1:0] presc_out;

    always #5 clk = ~clk;

    tmr_clock_select #(.PRESCALE_WIDTH(PW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cks       (cks),
        .icks0     (icks0),
        .tmci      (tmci),
        .tmri      (tmri),
        .tmri_en   (tmri_en),
        .tmris     (tmris),
        .ovf_in    (ovf_in),
        .count_en  (count_en),
        .ext_clr   (ext_clr),
        .presc_out (presc_out)
    );

    typedef struct {
        logic [2:0] cks;
        logic       icks0;
        int         tmci_hi;
        int         tmci_lo;
        int         tmci_periods;
        logic       tmri_en;
        logic       tmris;
        int         tmri_len;
        int         cycles;
        int         exp_ce;
        int         exp_first;
        int         exp_clr;
    } vec_t;

    int errors = 0;
    int checks = 0;

    // Model state: k = clock edges since reset release; p/F histories are pin samples and filtered levels.
    int       k;
    logic [3:0] tc_h;
    logic [3:0] tr_h;
    logic     tc_f, tc_fp, tr_f, tr_fp;
    int       ce_cnt, clr_cnt, first_ce;
    int       ce_at[$];

    function automatic vec_t mk(input logic [2:0] c, input logic i, input int hi, input int lo, input int per,
                                input logic en, input logic ms, input int rlen, input int cyc,
                                input int ece, input int efirst, input int eclr);
        vec_t v;
        v.cks = c; v.icks0 = i; v.tmci_hi = hi; v.tmci_lo = lo; v.tmci_periods = per;
        v.tmri_en = en; v.tmris = ms; v.tmri_len = rlen; v.cycles = cyc;
        v.exp_ce = ece; v.exp_first = efirst; v.exp_clr = eclr;
        return v;
    endfunction

    function automatic int div_n(input logic [2:0] c, input logic i);
        case (c)
            3'b001:  return i ? 2 : 8;
            3'b010:  return i ? 32 : 64;
            3'b011:  return i ? 1024 : 8192;
            default: return 0;
        endcase
    endfunction

    // Filtered level after this edge from the last three synchronized samples (h[1..3]).
    function automatic logic filt(input logic [3:0] h, input logic prev);
`ifdef TMR_INPUT_FILTER_EN
        if (h[3:1] == 3'b111) return 1'b1;
        if (h[3:1] == 3'b000) return 1'b0;
        return prev;
`else
        if (prev === 1'bx) return 1'b0;
        return h[1];
`endif
    endfunction

    task automatic check(input string nm, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp_v, k);
        end
    endtask

    task automatic model_reset();
        k = 0;
        tc_h = '0; tr_h = '0;
        tc_f = 1'b0; tc_fp = 1'b0; tr_f = 1'b0; tr_fp = 1'b0;
        ce_cnt = 0; clr_cnt = 0; first_ce = -1;
        ce_at.delete();
    endtask

    task automatic do_reset();
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        model_reset();
        check("reset_count_en", int'(count_en), 0);
        check("reset_ext_clr", int'(ext_clr), 0);
        check("reset_presc", int'(presc_out), 0);
    endtask

    // One clock: sample inputs, advance model, compare outputs 1 time unit after the edge.
    task automatic step();
        logic [2:0] c_cks;
        logic c_icks, c_tmci, c_tmri, c_en, c_ms, c_ovf;
        logic e_ce, e_clr, nf;
        int n, pre;
        c_cks = cks; c_icks = icks0; c_tmci = tmci; c_tmri = tmri;
        c_en = tmri_en; c_ms = tmris; c_ovf = ovf_in;
        @(posedge clk);
        k++;
        pre = (k - 1) % (1 << PW);
        n = div_n(c_cks, c_icks);
        e_ce = 1'b0;
        if (n > 0) begin
            e_ce = ((pre % n) == n - 1);
        end else begin
            case (c_cks)
                3'b100:  e_ce = c_ovf;
                3'b101:  e_ce = tc_f & ~tc_fp;
                3'b110:  e_ce = ~tc_f & tc_fp;
                3'b111:  e_ce = tc_f ^ tc_fp;
                default: e_ce = 1'b0;
            endcase
        end
        e_clr = c_en ? (c_ms ? tr_f : (tr_f & ~tr_fp)) : 1'b0;
        tc_h = {tc_h[2:0], c_tmci};
        nf = filt(tc_h, tc_f);
        tc_fp = tc_f; tc_f = nf;
        tr_h = {tr_h[2:0], c_tmri};
        nf = filt(tr_h, tr_f);
        tr_fp = tr_f; tr_f = nf;
        #1;
        check("count_en", int'(count_en), int'(e_ce));
        check("ext_clr", int'(ext_clr), int'(e_clr));
        check("presc_out", int'(presc_out), k % (1 << PW));
        if (count_en === 1'b1) begin
            ce_cnt++;
            if (first_ce < 0) first_ce = k;
            ce_at.push_back(k);
        end
        if (ext_clr === 1'b1) clr_cnt++;
    endtask

    task automatic run_vec(input vec_t v);
        do_reset();
        cks = v.cks; icks0 = v.icks0; tmri_en = v.tmri_en; tmris = v.tmris; ovf_in = 1'b0;
        for (int c = 0; c < v.cycles; c++) begin
            tmci = (c < v.tmci_periods * (v.tmci_hi + v.tmci_lo)) && ((c % (v.tmci_hi + v.tmci_lo)) < v.tmci_hi);
            tmri = (c >= 5) && (c < 5 + v.tmri_len);
            step();
        end
        tmci = 1'b0; tmri = 1'b0;
    endtask

    vec_t vecs[13];

    initial begin
        vecs[0]  = mk(3'b001, 1'b0, 1, 1, 0, 1'b0, 1'b0, 0, 64,    8,  8,    0);
        vecs[1]  = mk(3'b001, 1'b1, 1, 1, 0, 1'b0, 1'b0, 0, 64,    32, 2,    0);
        vecs[2]  = mk(3'b010, 1'b0, 1, 1, 0, 1'b0, 1'b0, 0, 256,   4,  64,   0);
        vecs[3]  = mk(3'b010, 1'b1, 1, 1, 0, 1'b0, 1'b0, 0, 256,   8,  32,   0);
        vecs[4]  = mk(3'b011, 1'b1, 1, 1, 0, 1'b0, 1'b0, 0, 3072,  3,  1024, 0);
        vecs[5]  = mk(3'b011, 1'b0, 1, 1, 0, 1'b0, 1'b0, 0, 16384, 2,  8192, 0);
        vecs[6]  = mk(3'b000, 1'b0, 1, 1, 0, 1'b0, 1'b0, 0, 20000, 0,  -1,   0);
        vecs[7]  = mk(3'b101, 1'b0, 4, 4, 10, 1'b0, 1'b0, 0, 100,  10, 3+FL, 0);
        vecs[8]  = mk(3'b111, 1'b0, 4, 4, 10, 1'b0, 1'b0, 0, 100,  20, 3+FL, 0);
        vecs[9]  = mk(3'b110, 1'b0, 4, 4, 10, 1'b0, 1'b0, 0, 100,  10, 7+FL, 0);
        vecs[10] = mk(3'b000, 1'b0, 1, 1, 0, 1'b1, 1'b0, 6, 40,    0,  -1,   1);
        vecs[11] = mk(3'b000, 1'b0, 1, 1, 0, 1'b1, 1'b1, 6, 40,    0,  -1,   6);
        vecs[12] = mk(3'b000, 1'b0, 1, 1, 0, 1'b0, 1'b1, 6, 40,    0,  -1,   0);
        model_reset();

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i]);
            check($sformatf("vec%0d_pulses", i), ce_cnt, vecs[i].exp_ce);
            check($sformatf("vec%0d_first", i), first_ce, vecs[i].exp_first);
            check($sformatf("vec%0d_clr_cycles", i), clr_cnt, vecs[i].exp_clr);
        end

        // Cascade: ovf_in in cycles 10 and 300 -> count_en in cycles 11 and 301.
        do_reset();
        cks = 3'b100;
        for (int c = 0; c < 400; c++) begin
            ovf_in = (c == 10) || (c == 300);
            step();
        end
        ovf_in = 1'b0;
        check("cascade_pulses", ce_cnt, 2);
        check("cascade_first", (ce_at.size() > 0) ? ce_at[0] : -1, 11);
        check("cascade_second", (ce_at.size() > 1) ? ce_at[1] : -1, 301);

        // Mid-stream reset at a cycle where count_en and ext_clr are both high.
        do_reset();
        cks = 3'b001; icks0 = 1'b0; tmri_en = 1'b1; tmris = 1'b1; tmri = 1'b1;
        for (int c = 0; c < 16; c++) begin
            tmci = (c % 4) >= 2;
            step();
        end
        check("pre_reset_count_en", int'(count_en), 1);
        check("pre_reset_ext_clr", int'(ext_clr), 1);
        reset_n = 1'b1;
        #1;
        check("async_reset_count_en", int'(count_en), 0);
        check("async_reset_ext_clr", int'(ext_clr), 0);
        check("async_reset_presc", int'(presc_out), 0);

        // Pin already high at release gives exactly one rising edge.
        tmci = 1'b1; tmri_en = 1'b0; tmri = 1'b0;
        do_reset();
        cks = 3'b101;
        for (int c = 0; c < 12; c++) step();
        check("held_high_pulses", ce_cnt, 1);
        check("held_high_first", first_ce, 3 + FL);
        tmci = 1'b0;

        // Short TMCI pulses: 2 cycles rejected only with the filter, 3 cycles always counted.
        do_reset();
        cks = 3'b101;
        for (int c = 0; c < 20; c++) begin
            tmci = (c >= 2) && (c < 4);
            step();
        end
        check("pulse2_count", ce_cnt, (FL > 0) ? 0 : 1);
        do_reset();
        for (int c = 0; c < 20; c++) begin
            tmci = (c >= 2) && (c < 5);
            step();
        end
        check("pulse3_count", ce_cnt, 1);

        // Randomized inputs, including selection changes and short pin pulses.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 63) == 0) begin
                cks = 3'($urandom_range(0, 7));
                icks0 = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 31) == 0) begin
                tmri_en = 1'($urandom_range(0, 1));
                tmris = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 3) == 0) tmci = ~tmci;
            if ($urandom_range(0, 4) == 0) tmri = ~tmri;
            ovf_in = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
